// File: rtl/fir_output_conditioner.sv
// Output conditioner behind fir_filter: rounds, scales and saturates y_in to OUT_W bits,
// decimates by DECIM and buffers results in a small FIFO behind a valid/ready interface.
module fir_output_conditioner #(
   parameter int unsigned IN_W       = 32,
   parameter int unsigned OUT_W      = 16,
   parameter int unsigned SHIFT      = 8,
   parameter int unsigned DECIM      = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic signed [IN_W-1:0]                y_in,
   input  logic                                  in_valid,
   output logic signed [OUT_W-1:0]               out_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]       level,
   output logic                                  sat_flag,
   output logic                                  overflow
);

   localparam int unsigned EXT_W = IN_W + 1;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int unsigned HI_W  = EXT_W - OUT_W + 1;

   localparam logic signed [EXT_W-1:0] RND  = EXT_W'(1) << (SHIFT - 1);
   localparam logic [OUT_W-1:0]        MAXV = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0]        MINV = {1'b1, {(OUT_W-1){1'b0}}};

   logic signed [EXT_W-1:0] w_ext;
   logic signed [EXT_W-1:0] w_rnd;
   logic signed [EXT_W-1:0] w_shr;
   logic [HI_W-1:0]         w_hi;
   logic                    w_sat;
   logic [OUT_W-1:0]        w_clamp;
   logic                    w_keep;
   logic [CNT_W-1:0]        w_dcnt_nxt;
   logic                    w_full;
   logic                    w_pop;
   logic                    w_push;
   logic                    w_drop;

   logic                    r_s_valid;
   logic [OUT_W-1:0]        r_s_data;
   logic [CNT_W-1:0]        r_dcnt;
   logic                    r_sat;
   logic                    r_overflow;
   logic [PTR_W-1:0]        r_wr_ptr;
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [LVL_W-1:0]        r_level;
   logic [OUT_W-1:0]        r_mem [FIFO_DEPTH];

   // Round half-up, arithmetic shift, then clamp if the discarded high bits are not pure sign.
   assign w_ext   = {y_in[IN_W-1], y_in};
   assign w_rnd   = w_ext + RND;
   assign w_shr   = w_rnd >>> SHIFT;
   assign w_hi    = w_shr[EXT_W-1:OUT_W-1];
   assign w_sat   = !((&w_hi) || (~|w_hi));
   assign w_clamp = w_sat ? (w_shr[EXT_W-1] ? MINV : MAXV) : w_shr[OUT_W-1:0];

   assign w_keep     = (r_dcnt == '0);
   assign w_dcnt_nxt = (r_dcnt == CNT_W'(DECIM - 1)) ? '0 : CNT_W'(r_dcnt + 1'b1);

   assign w_full = (r_level == LVL_W'(FIFO_DEPTH));
   assign w_pop  = out_valid & out_ready;
   assign w_push = r_s_valid & (!w_full | w_pop);
   assign w_drop = r_s_valid & w_full & !w_pop;

   // Conditioning stage and decimation counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s_valid <= 1'b0;
         r_s_data  <= '0;
         r_dcnt    <= '0;
         r_sat     <= 1'b0;
      end else if (in_valid) begin
         r_s_valid <= w_keep;
         r_s_data  <= w_clamp;
         r_dcnt    <= w_dcnt_nxt;
         if (w_sat) r_sat <= 1'b1;
      end else begin
         r_s_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_push) r_mem[r_wr_ptr] <= r_s_data;
   end

   // FIFO pointers, occupancy and sticky drop flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
         if (w_pop)  r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
         if (w_push && !w_pop)      r_level <= LVL_W'(r_level + 1'b1);
         else if (w_pop && !w_push) r_level <= LVL_W'(r_level - 1'b1);
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   assign out_valid = (r_level != '0);
   assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
   assign level     = r_level;
   assign sat_flag  = r_sat;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_fir_output_conditioner.sv
// Bench for fir_output_conditioner: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model of the conditioner.
module tb_fir_output_conditioner;

   localparam int unsigned IN_W       = 32;
   localparam int unsigned OUT_W      = 16;
   localparam int unsigned SHIFT      = 8;
   localparam int unsigned DECIM      = 2;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1);
   localparam longint      MAXV       = (64'sd1 <<< (OUT_W - 1)) - 1;
   localparam longint      MINV       = -(64'sd1 <<< (OUT_W - 1));

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic [IN_W-1:0]         y_in = '0;
   logic                    in_valid = 1'b0;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [LVL_W-1:0]        level;
   logic                    sat_flag;
   logic                    overflow;

   int errors = 0;
   int checks = 0;

   longint m_q[$];
   bit     m_sv;
   longint m_sd;
   int     m_dcnt;
   bit     m_sat;
   bit     m_ovf;
   longint pops[$];

   fir_output_conditioner #(
      .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(DECIM), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .y_in(y_in), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .sat_flag(sat_flag), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Round half-up to SHIFT fractional bits, then clamp to the signed OUT_W range.
   function automatic longint cond(input logic [IN_W-1:0] y, output bit sat);
      longint v = longint'($signed(y));
      longint r = (v + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
      sat = 1'b0;
      if (r > MAXV) begin r = MAXV; sat = 1'b1; end
      if (r < MINV) begin r = MINV; sat = 1'b1; end
      return r;
   endfunction

   task automatic model_edge(input bit iv, input logic [IN_W-1:0] y, input bit rdy, input bit rst);
      bit pop, acc, s;
      longint r;
      if (rst) begin
         m_q.delete();
         m_sv = 0; m_sd = 0; m_dcnt = 0; m_sat = 0; m_ovf = 0;
         return;
      end
      pop = (m_q.size() != 0) && rdy;
      acc = 0;
      if (m_sv) begin
         if (m_q.size() < FIFO_DEPTH || pop) acc = 1;
         else m_ovf = 1;
      end
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(m_sd);
      if (iv) begin
         r = cond(y, s);
         if (s) m_sat = 1;
         m_sv = (m_dcnt == 0);
         m_sd = r;
         m_dcnt = (m_dcnt + 1) % DECIM;
      end else begin
         m_sv = 0;
      end
   endtask

   // One clock: drive inputs, capture any handshake, advance model, compare 1ns after the edge.
   task automatic step(input bit iv, input logic [IN_W-1:0] y, input bit rdy, input bit rst = 0);
      in_valid = iv; y_in = y; out_ready = rdy; reset = rst;
      if (!rst && out_valid && rdy) pops.push_back(longint'(out_data));
      @(posedge clk);
      model_edge(iv, y, rdy, rst);
      #1;
      check("out_valid", longint'(out_valid), longint'(m_q.size() != 0));
      check("level", longint'(level), longint'(m_q.size()));
      check("out_data", longint'(out_data), (m_q.size() != 0) ? m_q[0] : 0);
      check("sat_flag", longint'(sat_flag), longint'(m_sat));
      check("overflow", longint'(overflow), longint'(m_ovf));
   endtask

   task automatic check_pops(input string tag, input longint exp[$]);
      check({tag, "_count"}, longint'(pops.size()), longint'(exp.size()));
      foreach (exp[i]) begin
         if (i < pops.size()) check(tag, pops[i], exp[i]);
      end
      pops.delete();
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, '0, rdy);
   endtask

   initial begin
      logic [IN_W-1:0] y;
      // 1: rounding and decimation
      step(0, '0, 1, 1);
      step(0, '0, 1, 1);
      check("rst_level", longint'(level), 0);
      check("rst_data", longint'(out_data), 0);
      step(1, 32'd256, 1);
      check("t1_lat_e", longint'(out_valid), 0);
      step(1, 32'd512, 1);
      check("t1_lat_e1", longint'(out_valid), 1);
      step(1, 32'd384, 1);
      step(1, 32'd1024, 1);
      step(1, -32'sd384, 1);
      step(1, 32'd0, 1);
      idle(4, 1);
      check_pops("t1_out", '{1, 2, -1});
      check("t1_sat", longint'(sat_flag), 0);
      check("t1_ovf", longint'(overflow), 0);

      // 2: saturation
      step(1, 32'h7FFF_FFFF, 1);
      step(1, 32'd0, 1);
      step(1, 32'h8000_0000, 1);
      step(1, 32'd0, 1);
      idle(4, 1);
      check_pops("t2_out", '{32767, -32768});
      check("t2_sat", longint'(sat_flag), 1);

      // 3: backpressure and overflow
      for (int k = 1; k <= 10; k++) step(1, IN_W'(k * 256), 0);
      idle(2, 0);
      check("t3_level", longint'(level), 4);
      check("t3_ovf", longint'(overflow), 1);
      idle(6, 1);
      check_pops("t3_out", '{1, 3, 5, 7});
      check("t3_empty", longint'(out_valid), 0);
      check("t3_level0", longint'(level), 0);

      // 4: full with simultaneous pop
      step(0, '0, 0, 1);
      for (int k = 1; k <= 9; k++) step(1, IN_W'(k * 256), 0);
      check("t4_full", longint'(level), 4);
      step(0, '0, 1);
      check("t4_level", longint'(level), 4);
      check("t4_ovf", longint'(overflow), 0);
      idle(6, 1);
      check_pops("t4_out", '{1, 3, 5, 7, 9});

      // 5: reset mid-stream
      step(1, 32'h7FFF_FFFF, 0);
      step(1, 32'd0, 0);
      step(1, 32'd256, 0);
      step(1, 32'd0, 0);
      step(1, 32'd512, 0);
      step(1, 32'd0, 0);
      idle(1, 0);
      check("t5_pre_level", longint'(level), 3);
      check("t5_pre_sat", longint'(sat_flag), 1);
      step(0, '0, 0, 1);
      check("t5_valid", longint'(out_valid), 0);
      check("t5_level", longint'(level), 0);
      check("t5_data", longint'(out_data), 0);
      check("t5_sat", longint'(sat_flag), 0);
      check("t5_ovf", longint'(overflow), 0);
      step(1, 32'd512, 1);
      idle(4, 1);
      check_pops("t5_out", '{2});

      // 6: gapped input, decimation counts valid samples only
      step(0, '0, 1, 1);
      step(1, 32'd256, 1);
      step(0, 32'hDEAD_BEEF, 1);
      step(0, 32'h1234_5678, 1);
      step(1, 32'd512, 1);
      step(1, 32'd768, 1);
      step(0, 32'h7FFF_FFFF, 1);
      step(1, 32'd1024, 1);
      idle(4, 1);
      check_pops("t6_out", '{1, 3});
      check("t6_sat", longint'(sat_flag), 0);

      // Random traffic against the model
      pops.delete();
      for (int n = 0; n < 3000; n++) begin
         case ($urandom_range(0, 3))
            0: y = IN_W'($urandom);
            1: y = IN_W'((int'($urandom_range(0, 128)) - 64) * 128);
            2: y = IN_W'(int'($urandom_range(8388352, 8388864)));
            default: y = IN_W'(-int'($urandom_range(8388352, 8388864)));
         endcase
         step(($urandom_range(0, 3) != 0), y, ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1,
              ($urandom_range(0, 499) == 0));
      end
      pops.delete();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
